// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: register map offsets and channel limit shared by board_io_ctrl and its debouncer
package io_ctrl_pkg;
  localparam int IO_MAX_CH = 32;
  localparam logic [4:0] IO_ADDR_IN       = 5'h00;
  localparam logic [4:0] IO_ADDR_OUT      = 5'h04;
  localparam logic [4:0] IO_ADDR_IRQ_EN   = 5'h08;
  localparam logic [4:0] IO_ADDR_PEND     = 5'h0C;
  localparam logic [4:0] IO_ADDR_EDGE_POL = 5'h10;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: one-channel synchroniser plus stability-counter debouncer with one-cycle rise/fall pulses
module io_debounce
  import io_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 100000
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic in_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d, differ, done;
  assign differ   = sync_q[SYNC_STAGES-1] ^ stable_q;
  assign done     = differ && cnt_q == CNT_MAX;
  assign stable_o = stable_q;
  assign rise_o   = done & ~stable_q;
  assign fall_o   = done & stable_q;
  // count consecutive differing cycles; flip the stable state once the run is long enough
  always_comb begin
    cnt_d    = (!differ || done) ? '0 : cnt_q + 1'b1;
    stable_d = done ? ~stable_q : stable_q;
  end
  // synchroniser chain, counter and stable state
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounced inputs with W1C pending/irq and LED output register; IO_EDGE_SEL_EN adds per-channel edge polarity
module board_io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int CH_IN       = 16,
  parameter int CH_OUT      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 100000
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [CH_IN-1:0]  in_i,
  output logic [CH_OUT-1:0] out_o,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [4:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ack_o,
  output logic [31:0]       rdata_o,
  output logic              irq_o
);
  logic [CH_IN-1:0] stable, rise, fall, ev;
  logic [CH_IN-1:0] irq_en_q, irq_en_d, pend_q, pend_d;
  logic [CH_OUT-1:0] out_q, out_d;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic [4:0] reg_addr;
  logic ack_q, irq_q, wr;
  logic unused_ok;
  assign reg_addr = {addr_i[4:2], 2'b00};
  assign wr       = req_i & we_i;
  for (genvar i = 0; i < CH_IN; i++) begin : g_deb
    io_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .in_i    (in_i[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end
`ifdef IO_EDGE_SEL_EN
  logic [CH_IN-1:0] pol_q, pol_d;
  assign pol_d     = (wr && reg_addr == IO_ADDR_EDGE_POL) ? wdata_i[CH_IN-1:0] : pol_q;
  assign ev        = (rise & ~pol_q) | (fall & pol_q);
  assign unused_ok = ^{wdata_i, addr_i[1:0]};
  // edge polarity register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) pol_q <= '0;
    else        pol_q <= pol_d;
  end
`else
  assign ev        = rise;
  assign unused_ok = ^{wdata_i, addr_i[1:0], fall};
`endif
  // register read multiplexer; unmapped offsets read zero
  always_comb begin
    rd_mux = reg_addr == IO_ADDR_IN     ? 32'(stable)   :
             reg_addr == IO_ADDR_OUT    ? 32'(out_q)    :
             reg_addr == IO_ADDR_IRQ_EN ? 32'(irq_en_q) :
             reg_addr == IO_ADDR_PEND   ? 32'(pend_q)   : '0;
`ifdef IO_EDGE_SEL_EN
    if (reg_addr == IO_ADDR_EDGE_POL) rd_mux = 32'(pol_q);
`endif
  end
  // register writes; a new event wins over a W1C clear on the same bit
  always_comb begin
    out_d    = (wr && reg_addr == IO_ADDR_OUT) ? wdata_i[CH_OUT-1:0] : out_q;
    irq_en_d = (wr && reg_addr == IO_ADDR_IRQ_EN) ? wdata_i[CH_IN-1:0] : irq_en_q;
    pend_d   = (pend_q & ~((wr && reg_addr == IO_ADDR_PEND) ? wdata_i[CH_IN-1:0] : '0)) | ev;
    rdata_d  = (req_i && !we_i) ? rd_mux : '0;
  end
  // bus response, control registers and registered interrupt
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      out_q    <= '0;
      irq_en_q <= '0;
      pend_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      ack_q    <= req_i;
      rdata_q  <= rdata_d;
      irq_q    <= |(pend_q & irq_en_q);
    end
  end
  assign out_o   = out_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed and random stimulus against a cycle-level behavioural model of board_io_ctrl
module tb_board_io_ctrl;
  localparam int CI = 4;
  localparam int CO = 4;
  localparam int SS = 2;
  localparam int DC = 4;
  logic clk_i = 1'b0, arst_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
  logic [CI-1:0] in_i = '0;
  logic [4:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [CO-1:0] out_o;
  logic ack_o, irq_o;
  logic [31:0] rdata_o;
  int n_chk = 0, n_fail = 0;
  logic [CI-1:0] hist[$];
  logic [CI-1:0] m_stable, m_pend, m_en, m_pol;
  logic [CO-1:0] m_out;
  logic m_ack, m_irq;
  logic [31:0] m_rdata;
  always #5 clk_i = ~clk_i;
  board_io_ctrl #(.CH_IN(CI), .CH_OUT(CO), .SYNC_STAGES(SS), .DEB_CYCLES(DC)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .in_i(in_i), .out_o(out_o), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o), .irq_o(irq_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    hist.delete();
    repeat (SS + DC) hist.push_back('0);
    m_stable = '0; m_pend = '0; m_en = '0; m_pol = '0; m_out = '0;
    m_ack = 1'b0; m_irq = 1'b0; m_rdata = '0;
  endtask
  // a channel's stable state flips when the raw input sampled over DC consecutive edges,
  // SS edges ago, all disagree with it
  task automatic model_edge();
    logic [CI-1:0] ns, ev, clr, s;
    logic [31:0] rd;
    bit all_diff;
    hist.push_back(in_i);
    void'(hist.pop_front());
    ns = m_stable; ev = '0; clr = '0;
    for (int i = 0; i < CI; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DC; k++) begin
        s = hist[k];
        if (s[i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        ns[i] = ~m_stable[i];
        ev[i] = m_pol[i] ? !ns[i] : ns[i];
      end
    end
    case (addr_i[4:2])
      3'd0: rd = 32'(m_stable);
      3'd1: rd = 32'(m_out);
      3'd2: rd = 32'(m_en);
      3'd3: rd = 32'(m_pend);
`ifdef IO_EDGE_SEL_EN
      3'd4: rd = 32'(m_pol);
`endif
      default: rd = 0;
    endcase
    m_irq = |(m_pend & m_en);
    m_ack = req_i;
    m_rdata = (req_i && !we_i) ? rd : 0;
    if (req_i && we_i) begin
      case (addr_i[4:2])
        3'd1: m_out = wdata_i[CO-1:0];
        3'd2: m_en = wdata_i[CI-1:0];
        3'd3: clr = wdata_i[CI-1:0];
`ifdef IO_EDGE_SEL_EN
        3'd4: m_pol = wdata_i[CI-1:0];
`endif
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | ev;
    m_stable = ns;
  endtask
  task automatic tick();
    @(posedge clk_i);
    if (!arst_i) model_edge();
    #1;
    check("out", 32'(out_o), 32'(m_out));
    check("irq", 32'(irq_o), 32'(m_irq));
    check("ack", 32'(ack_o), 32'(m_ack));
    check("rdata", rdata_o, m_rdata);
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    req_i = 1'b0; we_i = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    tick();
    check(tag, rdata_o, exp);
    req_i = 1'b0;
  endtask
  task automatic do_reset(input int n);
    arst_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
    model_reset();
    #1;
    check("rst_out", 32'(out_o), 0);
    check("rst_irq", 32'(irq_o), 0);
    ticks(n);
    arst_i = 1'b0;
  endtask
  initial begin
    do_reset(2);
    rd("rst_in", 5'h00, 0);
    rd("rst_pend", 5'h0C, 0);
    in_i[1] = 1'b1;
    ticks(3);
    in_i[1] = 1'b0;
    ticks(8);
    rd("glitch_in", 5'h00, 0);
    wr(5'h08, 32'h1);
    in_i[0] = 1'b1;
    ticks(8);
    rd("irq_pend", 5'h0C, 32'h1);
    check("irq_set", 32'(irq_o), 1);
    rd("deb_in", 5'h00, 32'h1);
    wr(5'h0C, 32'h1);
    tick();
    check("irq_clr", 32'(irq_o), 0);
    wr(5'h08, 32'h0);
    in_i[1] = 1'b1;
    ticks(8);
    rd("mask_pend", 5'h0C, 32'h2);
    check("mask_irq", 32'(irq_o), 0);
    wr(5'h08, 32'h2);
    tick();
    check("mask_irq_on", 32'(irq_o), 1);
    in_i[2] = 1'b1;
    ticks(5);
    wr(5'h0C, 32'h4);
    rd("collide_pend", 5'h0C, 32'h6);
    wr(5'h04, 32'hA);
    check("out_drv", 32'(out_o), 32'hA);
    rd("out_rd", 5'h04, 32'hA);
    rd("unmapped", 5'h14, 0);
    check("unmapped_ack", 32'(ack_o), 1);
`ifdef IO_EDGE_SEL_EN
    wr(5'h10, 32'h8);
    rd("pol_rd", 5'h10, 32'h8);
    in_i[3] = 1'b1;
    ticks(8);
    rd("pol_rise", 5'h0C, 32'h6);
    in_i[3] = 1'b0;
    ticks(8);
    rd("pol_fall", 5'h0C, 32'hE);
`else
    rd("pol_unmapped", 5'h10, 0);
    in_i[3] = 1'b1;
    ticks(8);
    rd("rise3", 5'h0C, 32'hE);
`endif
    req_i = 1'b1; we_i = 1'b0; addr_i = 5'h00;
    do_reset(2);
    check("rst_ack", 32'(ack_o), 0);
    rd("rst2_in", 5'h00, 0);
    rd("rst2_pend", 5'h0C, 0);
    check("rst2_out", 32'(out_o), 0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CI; i++) if ($urandom_range(0, 15) == 0) in_i[i] = ~in_i[i];
      req_i = $urandom_range(0, 2) == 0;
      we_i = $urandom_range(0, 1) == 1;
      addr_i = 5'($urandom_range(0, 31));
      wdata_i = $urandom;
      if ($urandom_range(0, 699) == 0) do_reset(2);
      else tick();
    end
    req_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
